// File: rtl/rca_pipe.sv
// -----------------------------------------------------------------------------
// rca_pipe
//
// Pipelined ripple-carry adder/subtractor behind valid/ready handshakes.
// The N-bit carry chain is cut into STAGES equal chunks of W = N/STAGES bits.
// Each chunk is added in its own register stage, and the carry ripples from
// one stage to the next. Stage 1 adds bits [W-1:0] and the last stage adds
// the top chunk. The last stage drives S/Co/Ovf/out_valid.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; clears all stages
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept an operand beat
//   Sub        in   0: add (A + B + Ci), 1: subtract (A - B)
//   Ci         in   carry-in, ignored when Sub = 1
//   A, B       in   N-bit operands (unsigned or two's complement)
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts result
//   S          out  N-bit sum / difference
//   Co         out  carry-out; in subtract mode 1 means no borrow
//   Ovf        out  signed overflow (carry into MSB xor carry out of MSB)
//
// Handshake: a beat moves across an interface at a rising clk edge where
// valid and ready are both high. Once out_valid is high, S/Co/Ovf hold until
// out_ready is seen high. Stage k advances when it is empty or the stage after
// it advances, so bubbles collapse. in_ready drops only when every stage holds
// a beat and out_ready is low. The out_ready -> in_ready path is the only
// combinational path through the block.
// -----------------------------------------------------------------------------
module rca_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         Sub,
    input  logic         Ci,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         Ovf
);

    localparam int W = N / STAGES;

    if ((N % STAGES) != 0) begin : g_bad_split
        $error("rca_pipe: N must be a multiple of STAGES");
    end

    // Ripple-carry add of one chunk.
    // Returns {carry out of chunk MSB, carry into chunk MSB, chunk sum}.
    function automatic logic [W+1:0] chunk_add(input logic [W-1:0] x,
                                               input logic [W-1:0] y,
                                               input logic         cin);
        logic [W-1:0] s;
        logic         c;
        logic         c_msb;
        s     = '0;
        c     = cin;
        c_msb = cin;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) c_msb = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, c_msb, s};
    endfunction

    // Stage registers, indexed 1..STAGES.
    // a_q/b_q carry the conditioned operands forward. Only bits above k*W are
    // still needed after stage k. r_q[k] holds the finished result bits
    // [k*W-1:0].
    logic         v_q [1:STAGES];
    logic [N-1:0] a_q [1:STAGES];
    logic [N-1:0] b_q [1:STAGES];
    logic [N-1:0] r_q [1:STAGES];
    logic         c_q [1:STAGES];
    logic         ovf_q;

    // Source of each stage: index 0 is the (conditioned) input port, and
    // index k is stage k.
    logic         src_v [0:STAGES-1];
    logic [N-1:0] src_a [0:STAGES-1];
    logic [N-1:0] src_b [0:STAGES-1];
    logic [N-1:0] src_r [0:STAGES-1];
    logic         src_c [0:STAGES-1];

    // Next-state values for each stage.
    logic         nxt_v  [1:STAGES];
    logic [N-1:0] nxt_a  [1:STAGES];
    logic [N-1:0] nxt_b  [1:STAGES];
    logic [N-1:0] nxt_r  [1:STAGES];
    logic         nxt_c  [1:STAGES];
    logic         nxt_cm [1:STAGES];

    logic [STAGES:1] adv;
    logic [W+1:0]    add;

    always_comb begin
        adv    = '0;
        add    = '0;
        src_v  = '{default: '0};
        src_a  = '{default: '0};
        src_b  = '{default: '0};
        src_r  = '{default: '0};
        src_c  = '{default: '0};
        nxt_v  = '{default: '0};
        nxt_a  = '{default: '0};
        nxt_b  = '{default: '0};
        nxt_r  = '{default: '0};
        nxt_c  = '{default: '0};
        nxt_cm = '{default: '0};

        // Advance enables, computed from the output end back to the input.
        adv[STAGES] = out_ready | ~v_q[STAGES];
        for (int k = STAGES - 1; k >= 1; k--) begin
            adv[k] = adv[k+1] | ~v_q[k];
        end

        // Subtraction is A + ~B + 1, so Ci is forced to 1 when Sub is set.
        src_v[0] = in_valid;
        src_a[0] = A;
        src_b[0] = Sub ? ~B : B;
        src_r[0] = '0;
        src_c[0] = Sub | Ci;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k];
            src_a[k] = a_q[k];
            src_b[k] = b_q[k];
            src_r[k] = r_q[k];
            src_c[k] = c_q[k];
        end

        // Stage k adds chunk k-1 with the carry left by the previous stage.
        for (int k = 1; k <= STAGES; k++) begin
            add = chunk_add(src_a[k-1][(k-1)*W +: W],
                            src_b[k-1][(k-1)*W +: W],
                            src_c[k-1]);
            nxt_v[k]               = src_v[k-1];
            nxt_a[k]               = src_a[k-1];
            nxt_b[k]               = src_b[k-1];
            nxt_r[k]               = src_r[k-1];
            nxt_r[k][(k-1)*W +: W] = add[W-1:0];
            nxt_c[k]               = add[W+1];
            nxt_cm[k]              = add[W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= nxt_v[k];
                    a_q[k] <= nxt_a[k];
                    b_q[k] <= nxt_b[k];
                    r_q[k] <= nxt_r[k];
                    c_q[k] <= nxt_c[k];
                end
            end
            // The last stage adds the MSB, so overflow is resolved there.
            if (adv[STAGES]) begin
                ovf_q <= nxt_c[STAGES] ^ nxt_cm[STAGES];
            end
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = v_q[STAGES];
    assign S         = r_q[STAGES];
    assign Co        = c_q[STAGES];
    assign Ovf       = ovf_q;

endmodule
